// File: rtl/brick_hit_scheduler.sv
// Brick grid hit-state owner for the breakout game.
// Each game tick a scan walks the 5x12 grid one brick per clock, in row-major order,
// and marks the first unhit brick that overlaps the ball box. The renderer reads the
// flags combinationally, and clear_all resets the grid for a new game.
//
// state    | meaning
// S_IDLE   | waiting for start; done low
// S_SCAN   | testing brick (r_row, r_col) this cycle
// S_REPORT | done pulse; hit/hit_row/hit_col valid
module brick_hit_scheduler #(
    parameter int ROWS        = 5,
    parameter int COLS        = 12,
    parameter int LEFT_WALL_X = 245,
    parameter int CEILING_Y   = 35,
    parameter int BLOCK_W     = 45,
    parameter int BLOCK_H     = 25,
    parameter int BALL_R      = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic       clear_all,
    output logic       busy,
    output logic       done,
    output logic       hit,
    output logic [2:0] hit_row,
    output logic [3:0] hit_col,
    output logic [5:0] bricks_left,
    output logic       all_clear,
    input  logic [2:0] rd_row,
    input  logic [3:0] rd_col,
    output logic       rd_hit
);

    localparam int NB = ROWS * COLS;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_REPORT} state_t;

    state_t          r_state;
    logic [9:0]      r_x;
    logic [9:0]      r_y;
    logic [2:0]      r_row;
    logic [3:0]      r_col;
    logic [NB-1:0]   r_flags;
    logic [5:0]      r_left;
    logic            r_busy;
    logic            r_done;
    logic            r_hit;
    logic [2:0]      r_hit_row;
    logic [3:0]      r_hit_col;

    logic [10:0]     w_bx;
    logic [10:0]     w_by;
    logic [10:0]     w_x;
    logic [10:0]     w_y;
    logic [5:0]      w_idx;
    logic [5:0]      w_rd_idx;
    logic            w_overlap;
    logic            w_last;

    // Bounds of the brick under test; no R is subtracted from the ball so nothing wraps below zero.
    assign w_bx      = 11'(LEFT_WALL_X) + 11'(r_col) * 11'(BLOCK_W);
    assign w_by      = 11'(CEILING_Y) + 11'(r_row) * 11'(BLOCK_H);
    assign w_x       = {1'b0, r_x};
    assign w_y       = {1'b0, r_y};
    assign w_overlap = (w_x + 11'(BALL_R) >= w_bx) &&
                       (w_x <= w_bx + 11'(BLOCK_W - 1 + BALL_R)) &&
                       (w_y + 11'(BALL_R) >= w_by) &&
                       (w_y <= w_by + 11'(BLOCK_H - 1 + BALL_R));
    assign w_idx     = 6'(r_row) * 6'(COLS) + 6'(r_col);
    assign w_last    = (r_row == 3'(ROWS - 1)) && (r_col == 4'(COLS - 1));
    assign w_rd_idx  = 6'(rd_row) * 6'(COLS) + 6'(rd_col);

    // Renderer read port; out-of-range coordinates read as unhit.
    always_comb begin
        rd_hit = 1'b0;
        if ((rd_row < 3'(ROWS)) && (rd_col < 4'(COLS)))
            rd_hit = r_flags[w_rd_idx];
    end

    // Scan FSM with registered outputs; clear_all overrides everything except reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_flags   <= '0;
            r_left    <= 6'(NB);
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hit     <= 1'b0;
            r_hit_row <= '0;
            r_hit_col <= '0;
        end else if (clear_all) begin
            r_state <= S_IDLE;
            r_flags <= '0;
            r_left  <= 6'(NB);
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_x     <= ball_x;
                        r_y     <= ball_y;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (!r_flags[w_idx] && w_overlap) begin
                        r_flags[w_idx] <= 1'b1;
                        r_left         <= r_left - 6'd1;
                        r_hit          <= 1'b1;
                        r_hit_row      <= r_row;
                        r_hit_col      <= r_col;
                        r_busy         <= 1'b0;
                        r_done         <= 1'b1;
                        r_state        <= S_REPORT;
                    end else if (w_last) begin
                        r_hit   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_REPORT;
                    end else if (r_col == 4'(COLS - 1)) begin
                        r_col <= '0;
                        r_row <= r_row + 3'd1;
                    end else begin
                        r_col <= r_col + 4'd1;
                    end
                end
                S_REPORT: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign hit         = r_hit;
    assign hit_row     = r_hit_row;
    assign hit_col     = r_hit_col;
    assign bricks_left = r_left;
    assign all_clear   = (r_left == 6'd0);

endmodule

// File: tb/tb_brick_hit_scheduler.sv
// Directed bench for brick_hit_scheduler: a reference grid model predicts each scan,
// predictions are queued at start and popped when done arrives.
module tb_brick_hit_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       clear_all;
    logic       busy;
    logic       done;
    logic       hit;
    logic [2:0] hit_row;
    logic [3:0] hit_col;
    logic [5:0] bricks_left;
    logic       all_clear;
    logic [2:0] rd_row;
    logic [3:0] rd_col;
    logic       rd_hit;

    brick_hit_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .ball_x(ball_x), .ball_y(ball_y),
        .clear_all(clear_all), .busy(busy), .done(done), .hit(hit),
        .hit_row(hit_row), .hit_col(hit_col), .bricks_left(bricks_left),
        .all_clear(all_clear), .rd_row(rd_row), .rd_col(rd_col), .rd_hit(rd_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit hit;
        int row;
        int col;
        int lat;
        int left;
    } exp_t;

    exp_t sb[$];
    bit   mflags[60];
    int   mleft;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit overlaps(input int x, input int y, input int r, input int c);
        int bx, by;
        bx = 245 + c * 45;
        by = 35 + r * 25;
        return (x + 5 >= bx) && (x <= bx + 44 + 5) && (y + 5 >= by) && (y <= by + 24 + 5);
    endfunction

    task automatic model_clear();
        foreach (mflags[i]) mflags[i] = 1'b0;
        mleft = 60;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        model_clear();
        check("clear_left", int'(bricks_left), 60);
        check("clear_busy", int'(busy), 0);
    endtask

    // One scan; inj_cycle > 0 pulses a competing start at that cycle of the scan.
    task automatic do_scan(input int x, input int y, input int inj_cycle, input string tag);
        exp_t e;
        bit   got;
        bit   busy_ok;
        int   dn;
        int   extra;
        e.hit = 1'b0; e.row = 0; e.col = 0; e.lat = 61;
        for (int k = 0; k < 60; k++) begin
            if (!mflags[k] && overlaps(x, y, k / 12, k % 12)) begin
                e.hit = 1'b1; e.row = k / 12; e.col = k % 12; e.lat = k + 2;
                mflags[k] = 1'b1;
                mleft--;
                break;
            end
        end
        e.left = mleft;
        sb.push_back(e);

        @(negedge clk);
        start = 1'b1; ball_x = 10'(x); ball_y = 10'(y);
        @(posedge clk);
        got = 1'b0; busy_ok = 1'b1; dn = 0;
        for (int n = 1; n <= 100 && !got; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                got = 1'b1; dn = n;
                if (busy) busy_ok = 1'b0;
            end else if (!busy) begin
                busy_ok = 1'b0;
            end
            if (n == inj_cycle) begin
                start = 1'b1; ball_x = 10'd250; ball_y = 10'd40;
            end
        end
        start = 1'b0;
        e = sb.pop_front();
        if (!got) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            check({tag, "_hit"}, int'(hit), int'(e.hit));
            if (e.hit) begin
                check({tag, "_row"}, int'(hit_row), e.row);
                check({tag, "_col"}, int'(hit_col), e.col);
            end
            check({tag, "_latency"}, dn, e.lat);
            check({tag, "_left"}, int'(bricks_left), e.left);
            check({tag, "_all_clear"}, int'(all_clear), (e.left == 0) ? 1 : 0);
            check({tag, "_busy"}, int'(busy_ok), 1);
        end
        if (inj_cycle > 0) begin
            extra = 0;
            for (int n = 0; n < 70; n++) begin
                @(negedge clk);
                if (done) extra++;
            end
            check({tag, "_extra_done"}, extra, 0);
        end
    endtask

    initial begin
        int dcount;
        rst = 1'b1; start = 1'b0; clear_all = 1'b0;
        ball_x = '0; ball_y = '0; rd_row = '0; rd_col = '0;
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_hit", int'(hit), 0);
        check("rst_hit_row", int'(hit_row), 0);
        check("rst_hit_col", int'(hit_col), 0);
        check("rst_left", int'(bricks_left), 60);
        check("rst_all_clear", int'(all_clear), 0);
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 12; c++) begin
                rd_row = 3'(r); rd_col = 4'(c);
                #1 check("rst_rd_hit", int'(rd_hit), 0);
            end
        end
        rd_row = 3'd5; rd_col = 4'd0;
        #1 check("rst_rd_row5", int'(rd_hit), 0);

        // Top-left hit, then the same ball misses
        do_scan(250, 40, 0, "tl_first");
        do_scan(250, 40, 0, "tl_repeat");
        rd_row = 3'd0; rd_col = 4'd0;
        #1 check("rd_00", int'(rd_hit), 1);

        // Ball below the grid
        do_scan(480, 300, 0, "below");

        // Box straddling col 0 and col 1 on a fresh grid
        do_clear();
        do_scan(290, 40, 0, "straddle1");
        do_scan(290, 40, 0, "straddle2");
        rd_row = 3'd0; rd_col = 4'd1;
        #1 check("rd_01", int'(rd_hit), 1);
        rd_row = 3'd0; rd_col = 4'd2;
        #1 check("rd_02", int'(rd_hit), 0);

        // Abort a scan with clear_all at cycle 10
        @(negedge clk);
        start = 1'b1; ball_x = 10'd480; ball_y = 10'd300;
        @(posedge clk);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        model_clear();
        check("abort_busy", int'(busy), 0);
        check("abort_left", int'(bricks_left), 60);
        rd_row = 3'd0; rd_col = 4'd1;
        #1 check("abort_rd_01", int'(rd_hit), 0);
        dcount = 0;
        for (int n = 0; n < 70; n++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("abort_no_done", dcount, 0);

        // A start during a scan is ignored
        do_scan(480, 300, 5, "ignored");

        // Hit every brick at its centre
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 12; c++) begin
                do_scan(245 + c * 45 + 22, 35 + r * 25 + 12, 0, "sweep");
            end
        end
        check("sweep_left", int'(bricks_left), 0);
        check("sweep_all_clear", int'(all_clear), 1);
        rd_row = 3'd4; rd_col = 4'd11;
        #1 check("rd_4_11", int'(rd_hit), 1);
        rd_row = 3'd5; rd_col = 4'd0;
        #1 check("rd_row5_full", int'(rd_hit), 0);
        rd_row = 3'd0; rd_col = 4'd12;
        #1 check("rd_col12_full", int'(rd_hit), 0);
        do_scan(245 + 22, 35 + 12, 0, "after_clear");

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
